axis_pattern_gen: RTL

Single-clock AXI-Stream transmitter that sources framed test traffic into the slave side of the stream FIFO wrapper. A run is started by a `start` pulse. The block emits a programmed number of frames, each of programmed byte length, with a deterministic incrementing byte pattern and fixed `tid`/`tdest`. It fully honours `tready` backpressure and exposes a sent-frame counter, so it drives the FIFO's input end on the bring-up and loopback paths.

---
 rtl/axis_pattern_gen.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/axis_pattern_gen.sv
// AXI-Stream pattern source: programmed frames of incrementing bytes with fixed tid/tdest.
// Define AXIS_PATTERN_GEN_GAP_EN to insert GAP_CYCLES idle cycles between frames of a run.
module axis_pattern_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int LEN_WIDTH  = 16,
  parameter int GAP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic [15:0]           frame_count,
  input  logic [ID_WIDTH-1:0]   cfg_id,
  input  logic [DEST_WIDTH-1:0] cfg_dest,
  output logic                  busy,
  output logic [31:0]           frames_sent,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND
`ifdef AXIS_PATTERN_GEN_GAP_EN
    , S_GAP
`endif
  } state_t;

  state_t                r_state, w_state;
  logic [LEN_WIDTH-1:0]  r_len, w_len, r_off, w_off;
  logic [15:0]           r_count, w_count, r_f, w_f;
  logic [ID_WIDTH-1:0]   r_id, w_id;
  logic [DEST_WIDTH-1:0] r_dest, w_dest;
  logic [31:0]           r_frames_sent, w_frames_sent;
  logic                  r_busy, w_busy, r_tvalid, w_tvalid, r_tlast, w_tlast;
  logic [DATA_WIDTH-1:0] r_tdata, w_tdata;
  logic [KEEP_WIDTH-1:0] r_tkeep, w_tkeep;
  logic [USER_WIDTH-1:0] r_tuser, w_tuser;
  logic                  w_load, w_hs;
  logic [7:0]            w_gen_f;
  logic [31:0]           w_gen_off, w_gen_len;
`ifdef AXIS_PATTERN_GEN_GAP_EN
  logic [31:0]           r_gap, w_gap;
`else
  logic                  w_unused_gap;
  assign w_unused_gap = (GAP_CYCLES != 0);
`endif

  always_comb begin
    w_state       = r_state;
    w_len         = r_len;
    w_off         = r_off;
    w_count       = r_count;
    w_f           = r_f;
    w_id          = r_id;
    w_dest        = r_dest;
    w_frames_sent = r_frames_sent;
    w_busy        = r_busy;
    w_tvalid      = r_tvalid;
    w_tlast       = r_tlast;
    w_tdata       = r_tdata;
    w_tkeep       = r_tkeep;
    w_tuser       = r_tuser;
    w_load        = 1'b0;
    w_hs          = r_tvalid && m_axis_tready;
    w_gen_f       = r_f[7:0];
    w_gen_off     = '0;
    w_gen_len     = 32'(r_len);
`ifdef AXIS_PATTERN_GEN_GAP_EN
    w_gap         = r_gap;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_len     = (frame_len == '0) ? LEN_WIDTH'(1) : frame_len;
          w_count   = frame_count;
          w_id      = cfg_id;
          w_dest    = cfg_dest;
          w_f       = '0;
          w_off     = '0;
          w_busy    = 1'b1;
          w_gen_f   = '0;
          w_gen_len = 32'(w_len);
          w_load    = 1'b1;
          w_state   = S_SEND;
        end
      end
      S_SEND: begin
        if (w_hs && !r_tlast) begin
          w_gen_off = 32'(r_off) + 32'(KEEP_WIDTH);
          w_off     = LEN_WIDTH'(w_gen_off);
          w_load    = 1'b1;
        end else if (w_hs) begin
          w_frames_sent = r_frames_sent + 32'd1;
          w_f           = r_f + 16'd1;
          w_off         = '0;
          w_tvalid      = 1'b0;
          w_tlast       = 1'b0;
          if (((r_count != '0) && (w_f == r_count)) || stop) begin
            w_busy  = 1'b0;
            w_state = S_IDLE;
          end else begin
`ifdef AXIS_PATTERN_GEN_GAP_EN
            w_gap   = 32'(GAP_CYCLES) - 32'd1;
            w_state = S_GAP;
`else
            // Next frame's first beat is loaded on the tlast handshake itself.
            w_gen_f = w_f[7:0];
            w_load  = 1'b1;
`endif
          end
        end
      end
`ifdef AXIS_PATTERN_GEN_GAP_EN
      S_GAP: begin
        if (stop) begin
          w_busy  = 1'b0;
          w_state = S_IDLE;
        end else if (r_gap == '0) begin
          w_load  = 1'b1;
          w_state = S_SEND;
        end else begin
          w_gap = r_gap - 32'd1;
        end
      end
`endif
      default: w_state = S_IDLE;
    endcase

    if (w_load) begin
      w_tvalid   = 1'b1;
      w_tdata    = '0;
      w_tkeep    = '0;
      w_tuser    = '0;
      w_tuser[0] = (w_gen_off == '0);
      w_tlast    = (w_gen_off + 32'(KEEP_WIDTH) >= w_gen_len);
      for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
        if (w_gen_off + i < w_gen_len) begin
          w_tdata[8*i +: 8] = w_gen_f + w_gen_off[7:0] + 8'(i);
          w_tkeep[i]        = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_len         <= '0;
      r_off         <= '0;
      r_count       <= '0;
      r_f           <= '0;
      r_id          <= '0;
      r_dest        <= '0;
      r_frames_sent <= '0;
      r_busy        <= 1'b0;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
      r_tdata       <= '0;
      r_tkeep       <= '0;
      r_tuser       <= '0;
`ifdef AXIS_PATTERN_GEN_GAP_EN
      r_gap         <= '0;
`endif
    end else begin
      r_state       <= w_state;
      r_len         <= w_len;
      r_off         <= w_off;
      r_count       <= w_count;
      r_f           <= w_f;
      r_id          <= w_id;
      r_dest        <= w_dest;
      r_frames_sent <= w_frames_sent;
      r_busy        <= w_busy;
      r_tvalid      <= w_tvalid;
      r_tlast       <= w_tlast;
      r_tdata       <= w_tdata;
      r_tkeep       <= w_tkeep;
      r_tuser       <= w_tuser;
`ifdef AXIS_PATTERN_GEN_GAP_EN
      r_gap         <= w_gap;
`endif
    end
  end

  assign busy          = r_busy;
  assign frames_sent   = r_frames_sent;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tkeep  = r_tkeep;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tid    = r_id;
  assign m_axis_tdest  = r_dest;
  assign m_axis_tuser  = r_tuser;

endmodule
